// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 Hz VGA raster generator for the 25 MHz pixel clock.
//   Free-running column/line counters feed the downstream pixel painter. The
//   painter's pixel comes back PIX_LATENCY clocks later. It is blanked outside
//   the active window and registered to the VGA pins. Sync is delayed by the
//   same amount so that sync and colour leave together.
//
// Ports
//   clk_25      in   pixel clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   h_count     out  current column, 0..H_TOTAL-1
//   v_count     out  current line, 0..V_TOTAL-1
//   frame_tick  out  high while the counters sit at (0,0)
//   rgb_in      in   painter pixel, RRRGGGBB, PIX_LATENCY clocks after its count
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   vga_red     out  rgb_in[7:5] or 0 when blanked
//   vga_green   out  rgb_in[4:2] or 0 when blanked
//   vga_blue    out  rgb_in[1:0] or 0 when blanked
//
// Parameter ordering must hold: H_SYNC < H_ACT_START < H_ACT_END <= H_TOTAL <= 1024,
// and the same ordering vertically. PIX_LATENCY is legal from 1 to 4.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_ACT_START = 144,
   parameter int H_ACT_END   = 784,
   parameter int V_TOTAL     = 521,
   parameter int V_SYNC      = 2,
   parameter int V_ACT_START = 31,
   parameter int V_ACT_END   = 511,
   parameter int PIX_LATENCY = 1
) (
   input  logic       clk_25,
   input  logic       rst_n,
   output logic [9:0] h_count,
   output logic [9:0] v_count,
   output logic       frame_tick,
   input  logic [7:0] rgb_in,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] vga_red,
   output logic [2:0] vga_green,
   output logic [1:0] vga_blue
);

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SW    = 10'(H_SYNC);
   localparam logic [9:0] V_SW    = 10'(V_SYNC);
   localparam logic [9:0] H_A0    = 10'(H_ACT_START);
   localparam logic [9:0] H_A1    = 10'(H_ACT_END);
   localparam logic [9:0] V_A0    = 10'(V_ACT_START);
   localparam logic [9:0] V_A1    = 10'(V_ACT_END);

   logic                   hs_raw, vs_raw, von_raw;
   logic [PIX_LATENCY-1:0] hs_pipe, vs_pipe, von_pipe;
   logic [7:0]             rgb_q;

   // ---------------- raster counters ----------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         h_count <= '0;
         v_count <= '0;
      end else if (h_count == H_LAST) begin
         h_count <= '0;
         v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
      end else begin
         h_count <= h_count + 10'd1;
      end
   end

   assign frame_tick = (h_count == 10'd0) && (v_count == 10'd0);

   // ---------------- raw timing ----------------
   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      hs_raw  = 1'b1;
      vs_raw  = 1'b1;
      von_raw = 1'b0;
      if (h_count < H_SW) hs_raw = 1'b0;
      // vsync depends only on v_count, so it can only change at the line wrap.
      if (v_count < V_SW) vs_raw = 1'b0;
      if ((h_count >= H_A0) && (h_count < H_A1) &&
          (v_count >= V_A0) && (v_count < V_A1))
         von_raw = 1'b1;
   end

   // ---------------- alignment pipeline ----------------
   // Stage 0 takes the raw value; stage PIX_LATENCY-1 lines up with rgb_in.
   // Sync stages reset to the inactive level so the pins stay high while the
   // pipeline refills after reset.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         hs_pipe  <= '1;
         vs_pipe  <= '1;
         von_pipe <= '0;
      end else begin
         hs_pipe[0]  <= hs_raw;
         vs_pipe[0]  <= vs_raw;
         von_pipe[0] <= von_raw;
         for (int i = 1; i < PIX_LATENCY; i++) begin
            hs_pipe[i]  <= hs_pipe[i-1];
            vs_pipe[i]  <= vs_pipe[i-1];
            von_pipe[i] <= von_pipe[i-1];
         end
      end
   end

   // ---------------- output register ----------------
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         rgb_q <= '0;
      end else begin
         hsync <= hs_pipe[PIX_LATENCY-1];
         vsync <= vs_pipe[PIX_LATENCY-1];
         rgb_q <= von_pipe[PIX_LATENCY-1] ? rgb_in : 8'h00;
      end
   end

   assign vga_red   = rgb_q[7:5];
   assign vga_green = rgb_q[4:2];
   assign vga_blue  = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clock and reset:
//     dut_a : full 640x480 timing, PIX_LATENCY=1, random painter pixels.
//     dut_b : shrunken 40x20 raster, PIX_LATENCY=3, painter returns the
//             column number of the count three clocks earlier.
//   Expected values come from a position model: after reset release, edge k
//   puts the raster at linear position k, and the pins show position k-L-1.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   // small raster for dut_b so that whole frames fit in a short run
   localparam int BHT = 40, BHS = 4, BHA0 = 8,  BHA1 = 36;
   localparam int BVT = 20, BVS = 2, BVA0 = 4,  BVA1 = 18;
   localparam int BLAT = 3;
   localparam int BFRAME = BHT * BVT;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       von;
   } ras_t;

   logic       clk_25 = 1'b0;
   logic       rst_n;
   logic [7:0] rgb_a, rgb_b;
   logic [9:0] h_a, v_a, h_b, v_b;
   logic       ft_a, ft_b, hs_a, hs_b, vs_a, vs_b;
   logic [2:0] r_a, g_a, r_b, g_b;
   logic [1:0] b_a, b_b;

   int checks = 0;
   int errors = 0;
   int k;
   int hs_low_a, vs_low_b, first_hs_a, first_hs_b, first_tick_b, ticks_b;

   always #20 clk_25 = ~clk_25;

   vga_timing_gen dut_a (
      .clk_25(clk_25), .rst_n(rst_n), .h_count(h_a), .v_count(v_a),
      .frame_tick(ft_a), .rgb_in(rgb_a), .hsync(hs_a), .vsync(vs_a),
      .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a));

   vga_timing_gen #(
      .H_TOTAL(BHT), .H_SYNC(BHS), .H_ACT_START(BHA0), .H_ACT_END(BHA1),
      .V_TOTAL(BVT), .V_SYNC(BVS), .V_ACT_START(BVA0), .V_ACT_END(BVA1),
      .PIX_LATENCY(BLAT)
   ) dut_b (
      .clk_25(clk_25), .rst_n(rst_n), .h_count(h_b), .v_count(v_b),
      .frame_tick(ft_b), .rgb_in(rgb_b), .hsync(hs_b), .vsync(vs_b),
      .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b));

   // raster position -> timing, straight from the line/frame arithmetic
   function automatic ras_t raster(int pos, int ht, int hsw, int ha0, int ha1,
                                   int vt, int vsw, int va0, int va1);
      ras_t r;
      int p, h, v;
      p = pos % (ht * vt);
      h = p % ht;
      v = p / ht;
      r.h   = 10'(h);
      r.v   = 10'(v);
      r.hs  = (h >= hsw);
      r.vs  = (v >= vsw);
      r.von = (h >= ha0) && (h < ha1) && (v >= va0) && (v < va1);
      return r;
   endfunction

   function automatic ras_t ras_a(int pos);
      return raster(pos, 800, 96, 144, 784, 521, 2, 31, 511);
   endfunction

   function automatic ras_t ras_b(int pos);
      return raster(pos, BHT, BHS, BHA0, BHA1, BVT, BVS, BVA0, BVA1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_reset_values();
      check("rst_h_a", 32'(h_a), 0);   check("rst_v_a", 32'(v_a), 0);
      check("rst_ft_a", 32'(ft_a), 1); check("rst_hs_a", 32'(hs_a), 1);
      check("rst_vs_a", 32'(vs_a), 1); check("rst_col_a", 32'({r_a, g_a, b_a}), 0);
      check("rst_h_b", 32'(h_b), 0);   check("rst_v_b", 32'(v_b), 0);
      check("rst_ft_b", 32'(ft_b), 1); check("rst_hs_b", 32'(hs_b), 1);
      check("rst_vs_b", 32'(vs_b), 1); check("rst_col_b", 32'({r_b, g_b, b_b}), 0);
   endtask

   // Compare both instances against the model for edge k. rgb_a still holds
   // the pixel presented before this edge, i.e. the one that was registered.
   task automatic check_cycle();
      ras_t c, o;
      logic [7:0] col;
      // dut_a: counters at position k, pins at position k-2
      c = ras_a(k);
      check("h_a", 32'(h_a), 32'(c.h));
      check("v_a", 32'(v_a), 32'(c.v));
      check("ft_a", 32'(ft_a), 32'(c.h == 0 && c.v == 0));
      if (k >= 2) begin
         o = ras_a(k - 2);
         col = o.von ? rgb_a : 8'h00;
         check("hs_a", 32'(hs_a), 32'(o.hs));
         check("vs_a", 32'(vs_a), 32'(o.vs));
      end else begin
         col = 8'h00;
         check("hs_a", 32'(hs_a), 1);
         check("vs_a", 32'(vs_a), 1);
      end
      check("col_a", 32'({r_a, g_a, b_a}), 32'(col));
      // dut_b: counters at position k, pins at position k-4, colour = column
      c = ras_b(k);
      check("h_b", 32'(h_b), 32'(c.h));
      check("v_b", 32'(v_b), 32'(c.v));
      check("ft_b", 32'(ft_b), 32'(c.h == 0 && c.v == 0));
      if (k >= BLAT + 1) begin
         o = ras_b(k - BLAT - 1);
         col = o.von ? o.h[7:0] : 8'h00;
         check("hs_b", 32'(hs_b), 32'(o.hs));
         check("vs_b", 32'(vs_b), 32'(o.vs));
      end else begin
         col = 8'h00;
         check("hs_b", 32'(hs_b), 1);
         check("vs_b", 32'(vs_b), 1);
      end
      check("col_b", 32'({r_b, g_b, b_b}), 32'(col));
   endtask

   // painter stimulus for the cycle following edge k
   task automatic drive_pixels();
      ras_t p;
      rgb_a = 8'($urandom);
      if (k >= BLAT) begin
         p = ras_b(k - BLAT);
         rgb_b = p.h[7:0];
      end else begin
         rgb_b = 8'($urandom);
      end
   endtask

   task automatic restart_stats();
      k = 0;
      hs_low_a = 0; vs_low_b = 0; ticks_b = 0;
      first_hs_a = -1; first_hs_b = -1; first_tick_b = -1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk_25);
         k++;
         @(negedge clk_25);
         check_cycle();
         if (k >= 2 && k < 2402 && !hs_a) hs_low_a++;
         if (k >= BLAT + 1 && k < BLAT + 1 + 2 * BFRAME && !vs_b) vs_low_b++;
         if (first_hs_a < 0 && !hs_a) first_hs_a = k;
         if (first_hs_b < 0 && !hs_b) first_hs_b = k;
         if (ft_b && k <= 2 * BFRAME) ticks_b++;
         if (first_tick_b < 0 && ft_b) first_tick_b = k;
         drive_pixels();
      end
   endtask

   initial begin
      // reset held for 5 clocks
      rst_n = 1'b0;
      rgb_a = 8'hFF;
      rgb_b = 8'hFF;
      restart_stats();
      repeat (5) begin
         @(negedge clk_25);
         check_reset_values();
      end
      drive_pixels();
      rst_n = 1'b1;

      // 33 full-size lines covers line 30 and the first active lines of
      // dut_a, and more than 30 frames of dut_b
      run(26500);
      check("hs_low_3lines_a", 32'(hs_low_a), 3 * 96);
      check("hs_first_fall_a", 32'(first_hs_a), 2);
      check("hs_first_fall_b", 32'(first_hs_b), BLAT + 1);
      check("vs_low_2frames_b", 32'(vs_low_b), 2 * BVS * BHT);
      check("ticks_2frames_b", 32'(ticks_b), 2);
      check("first_tick_b", 32'(first_tick_b), BFRAME);

      // mid-frame reset: outputs must clear before the next clock edge
      @(posedge clk_25);
      #5 rst_n = 1'b0;
      #1 check_reset_values();
      @(posedge clk_25);
      @(negedge clk_25);
      check_reset_values();
      restart_stats();
      drive_pixels();
      rst_n = 1'b1;

      run(2 * BFRAME + 100);
      check("first_tick_after_rst_b", 32'(first_tick_b), BFRAME);
      check("hs_first_fall_after_rst_b", 32'(first_hs_b), BLAT + 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
